uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, line idles high.
//
// Each bit is sampled once, near its middle. A start edge is confirmed half a
// bit period after it is seen, and each later sample is one full bit period
// after the previous one. A byte is published only when its stop bit is high.
// A frame with a low stop bit raises a framing-error pulse. The receiver then
// waits for the line to go high again, so a held-low line (break) produces
// only one error.
//
// Parameters:
//   CLK_RATE     system clock frequency in Hz
//   BAUD_RATE    line bit rate
//
// Ports:
//   clk          system clock; all logic runs in this one domain
//   reset        synchronous, active-high reset
//   rx           asynchronous serial input, idle high
//   rx_ack       consumer pulse that clears rx_valid
//   rx_data      last correctly framed byte
//   rx_valid     high while rx_data holds an unacknowledged byte
//   rx_busy      high while a frame is being received
//   rx_frame_err one-cycle pulse on a low stop bit
//   rx_overrun   one-cycle pulse when an unacknowledged byte is overwritten
module uart_rx #(
  parameter int CLK_RATE  = 12000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int BIT_PERIOD  = CLK_RATE / BAUD_RATE;
  localparam int HALF_PERIOD = BIT_PERIOD / 2;

  localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic        r_rx_meta;
  logic        r_rx_s;
  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_frame_err;
  logic        r_overrun;

  logic        w_busy;

  assign w_busy = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rx_meta   <= rx;
      r_rx_s      <= r_rx_meta;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      // An acknowledge clears the held byte. A byte accepted in this same
      // cycle assigns r_valid again further down, and that later assignment
      // takes priority.
      if (r_valid && rx_ack) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_cnt <= 16'd0;
          if (!r_rx_s) begin
            r_state <= S_START;
          end
        end

        S_START: begin
          if (r_cnt == HALF_LAST) begin
            // Check mid start bit: a pulse shorter than half a bit is treated as noise.
            if (!r_rx_s) begin
              r_state   <= S_DATA;
              r_cnt     <= 16'd0;
              r_bit_idx <= 3'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (r_cnt == BIT_LAST) begin
            // LSB arrives first, so after 8 right shifts it sits in bit 0.
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_cnt     <= 16'd0;
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt <= 16'd0;
            if (r_rx_s) begin
              r_data    <= r_shift;
              r_valid   <= 1'b1;
              r_overrun <= r_valid && !rx_ack;
              r_state   <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_WAIT_HIGH: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_busy      = w_busy;
  assign rx_frame_err = r_frame_err;
  assign rx_overrun   = r_overrun;

endmodule
